// File: rtl/keypad_entry_scanner_pkg.sv
// Shared types, key constants and the keypad map for the keypad entry scanner.
// The map ties each column/row intersection of the 4x4 matrix to its hex legend.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_kind_e;

  typedef struct packed {
    frame_kind_e kind;
    logic [3:0]  code;
  } frame_result_t;

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [2:0] ENTRY_MAX = 3'd4;

  // Legend printed on a Pmod KYPD style pad, addressed by driven column and sensed row.
  function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    code = 4'h0;
    case ({col, row})
      4'h0: code = 4'h1;
      4'h1: code = 4'h4;
      4'h2: code = 4'h7;
      4'h3: code = 4'h0;
      4'h4: code = 4'h2;
      4'h5: code = 4'h5;
      4'h6: code = 4'h8;
      4'h7: code = 4'hF;
      4'h8: code = 4'h3;
      4'h9: code = 4'h6;
      4'hA: code = 4'h9;
      4'hB: code = 4'hE;
      4'hC: code = 4'hA;
      4'hD: code = 4'hB;
      4'hE: code = 4'hC;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/keypad_entry_scanner_if.sv
// Keypad pins plus the key event and entry buffer outputs of the scanner.
// master is the scanner side; slave is whatever drives the rows and consumes the results.
interface keypad_entry_scanner_if;

  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] Dig_1;
  logic [3:0] Dig_2;
  logic [3:0] Dig_3;
  logic [3:0] Dig_4;
  logic [2:0] entry_count;
  logic       entry_done;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output Dig_1,
    output Dig_2,
    output Dig_3,
    output Dig_4,
    output entry_count,
    output entry_done
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  Dig_1,
    input  Dig_2,
    input  Dig_3,
    input  Dig_4,
    input  entry_count,
    input  entry_done
  );

endinterface

// File: rtl/keypad_entry_scanner_frame_scan.sv
// Column driver and frame classifier for an active-low 4x4 matrix keypad.
// Emits one NONE/SINGLE/MULTI result per full scan, strobed on the column-3 sample edge.
module keypad_frame_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    i_row_n,
  output logic [3:0]    o_col_n,
  output logic          o_frame_done,
  output frame_result_t o_frame
);

  localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col_n;
  logic [1:0]       r_acc_hits;
  logic [3:0]       r_acc_code;

  logic             w_tick;
  logic             w_last_col;
  logic [3:0]       w_row_low;
  logic [2:0]       w_col_hits;
  logic [2:0]       w_total;
  logic [3:0]       w_col_code;

  // NOTE: flops take <= so every register samples pre-edge values; the synchronizer
  // resets to all-high (no key) so a held key is never seen during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= i_row_n;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_tick     = (r_div == DIV_LAST);
  assign w_last_col = (r_col_idx == 2'd3);
  assign w_row_low  = ~r_row_sync;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_col_hits = 3'd0;
    w_col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (w_row_low[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_col_code = key_map(r_col_idx, 2'(r));
      end
    end
    w_total = w_col_hits + {1'b0, r_acc_hits};
  end

  // The code only matters when the whole frame saw exactly one intersection.
  always_comb begin
    o_frame.kind = FR_MULTI;
    o_frame.code = (w_col_hits != 3'd0) ? w_col_code : r_acc_code;
    if (w_total == 3'd0) begin
      o_frame.kind = FR_NONE;
    end else if (w_total == 3'd1) begin
      o_frame.kind = FR_SINGLE;
    end
  end

  assign o_frame_done = w_tick && w_last_col;
  assign o_col_n      = r_col_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div      <= '0;
      r_col_idx  <= 2'd0;
      r_col_n    <= 4'b1110;
      r_acc_hits <= 2'd0;
      r_acc_code <= 4'h0;
    end else if (w_tick) begin
      r_div     <= '0;
      r_col_idx <= r_col_idx + 2'd1;
      r_col_n   <= {r_col_n[2:0], r_col_n[3]};
      if (w_last_col) begin
        r_acc_hits <= 2'd0;
        r_acc_code <= 4'h0;
      end else begin
        // Two or more hits already make the frame MULTI, so the count saturates at 2.
        r_acc_hits <= (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
        if (w_col_hits == 3'd1) begin
          r_acc_code <= w_col_code;
        end
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/keypad_entry_scanner.sv
// Keypad scanner top: frame-level press/release debounce and a four-digit entry buffer.
// Digits shift in from Dig_1; C clears the buffer, E pulses entry_done.
module keypad_entry_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  keypad_entry_scanner_if.master kp
);

  localparam logic [3:0] CNT_TARGET = 4'(DEBOUNCE_FRAMES);

  logic          w_frame_done;
  frame_result_t w_frame;

  scan_state_e   r_state;
  scan_state_e   w_state_nx;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_nx;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nx;
  logic [3:0]    w_cnt_inc;
  logic          w_accept;
  logic          w_is_single;
  logic          w_is_none;

  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic          r_entry_done;
  logic [3:0]    r_dig1;
  logic [3:0]    r_dig2;
  logic [3:0]    r_dig3;
  logic [3:0]    r_dig4;
  logic [2:0]    r_entry_count;

  keypad_frame_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_frame_scan (
    .clk         (clk),
    .reset       (reset),
    .i_row_n     (kp.row_in),
    .o_col_n     (kp.col_out),
    .o_frame_done(w_frame_done),
    .o_frame     (w_frame)
  );

  assign w_is_single = (w_frame.kind == FR_SINGLE);
  assign w_is_none   = (w_frame.kind == FR_NONE);
  assign w_cnt_inc   = r_cnt + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cand  <= 4'h0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // The FSM only moves on frame strobes; between them everything holds.
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    if (w_frame_done) begin
      case (r_state)
        IDLE: begin
          if (w_is_single) begin
            w_cand_nx = w_frame.code;
            w_cnt_nx  = 4'd1;
            if (CNT_TARGET == 4'd1) begin
              w_accept   = 1'b1;
              w_state_nx = HELD;
            end else begin
              w_state_nx = PRESS_PEND;
            end
          end
        end
        PRESS_PEND: begin
          if (w_is_single && (w_frame.code == r_cand)) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == CNT_TARGET) begin
              w_accept   = 1'b1;
              w_state_nx = HELD;
            end
          end else begin
            w_state_nx = IDLE;
          end
        end
        HELD: begin
          if (w_is_none) begin
            w_cnt_nx   = 4'd1;
            w_state_nx = (CNT_TARGET == 4'd1) ? IDLE : RELEASE_PEND;
          end
        end
        RELEASE_PEND: begin
          if (w_is_none) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == CNT_TARGET) begin
              w_state_nx = IDLE;
            end
          end else begin
            w_state_nx = HELD;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Key event and buffer update land on the same edge as the accepting frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_code    <= 4'h0;
      r_key_valid   <= 1'b0;
      r_entry_done  <= 1'b0;
      r_dig1        <= 4'h0;
      r_dig2        <= 4'h0;
      r_dig3        <= 4'h0;
      r_dig4        <= 4'h0;
      r_entry_count <= 3'd0;
    end else begin
      r_key_valid  <= w_accept;
      r_entry_done <= w_accept && (w_cand_nx == KEY_ENTER);
      if (w_accept) begin
        r_key_code <= w_cand_nx;
        if (is_digit(w_cand_nx)) begin
          r_dig4 <= r_dig3;
          r_dig3 <= r_dig2;
          r_dig2 <= r_dig1;
          r_dig1 <= w_cand_nx;
          if (r_entry_count != ENTRY_MAX) begin
            r_entry_count <= r_entry_count + 3'd1;
          end
        end else if (w_cand_nx == KEY_CLEAR) begin
          r_dig1        <= 4'h0;
          r_dig2        <= 4'h0;
          r_dig3        <= 4'h0;
          r_dig4        <= 4'h0;
          r_entry_count <= 3'd0;
        end
      end
    end
  end

  assign kp.key_code    = r_key_code;
  assign kp.key_valid   = r_key_valid;
  assign kp.entry_done  = r_entry_done;
  assign kp.Dig_1       = r_dig1;
  assign kp.Dig_2       = r_dig2;
  assign kp.Dig_3       = r_dig3;
  assign kp.Dig_4       = r_dig4;
  assign kp.entry_count = r_entry_count;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner with a frame-level behavioural model.
// A 16-bit pressed-key mask drives a matrix model; every output is compared each cycle.
module tb_keypad_entry_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int          DEB      = 2;
  localparam int          FRAME    = 16;

  logic        clk;
  logic        reset;
  logic [15:0] mask;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_done   = 0;

  keypad_entry_scanner_if kp_if ();

  keypad_entry_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pressed key index is col*4+row; a row reads low when a pressed key sits on the driven column.
  always_comb begin
    kp_if.row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!kp_if.col_out[c] && mask[c*4+r]) kp_if.row_in[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] key_at(input int idx);
    case (idx)
      0: return 4'h1;   1: return 4'h4;   2: return 4'h7;   3: return 4'h0;
      4: return 4'h2;   5: return 4'h5;   6: return 4'h8;   7: return 4'hF;
      8: return 4'h3;   9: return 4'h6;  10: return 4'h9;  11: return 4'hE;
      12: return 4'hA; 13: return 4'hB;  14: return 4'hC;  default: return 4'hD;
    endcase
  endfunction

  function automatic logic [15:0] key_bit(input logic [3:0] code);
    logic [15:0] b;
    b = 16'h0;
    for (int i = 0; i < 16; i++) if (key_at(i) == code) b[i] = 1'b1;
    return b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_k;
  logic [15:0] m_hist0, m_hist1;
  int          m_run, m_rel, m_acc_hits;
  bit          m_held;
  logic [3:0]  m_cand, m_acc_code;
  logic [3:0]  e_col, e_code, e_d1, e_d2, e_d3, e_d4;
  logic [2:0]  e_cnt;
  logic        e_valid, e_done;

  task automatic model_reset();
    m_k = 0; m_hist0 = 16'h0; m_hist1 = 16'h0;
    m_run = 0; m_rel = 0; m_held = 1'b0; m_cand = 4'h0;
    m_acc_hits = 0; m_acc_code = 4'h0;
    e_col = 4'hE; e_code = 4'h0; e_valid = 1'b0; e_done = 1'b0;
    e_d1 = 4'h0; e_d2 = 4'h0; e_d3 = 4'h0; e_d4 = 4'h0; e_cnt = 3'd0;
  endtask

  task automatic model_accept(input logic [3:0] key);
    e_code  = key;
    e_valid = 1'b1;
    if (key <= 4'h9) begin
      e_d4 = e_d3; e_d3 = e_d2; e_d2 = e_d1; e_d1 = key;
      if (e_cnt < 3'd4) e_cnt = e_cnt + 3'd1;
    end else if (key == 4'hC) begin
      e_d1 = 4'h0; e_d2 = 4'h0; e_d3 = 4'h0; e_d4 = 4'h0; e_cnt = 3'd0;
    end else if (key == 4'hE) begin
      e_done = 1'b1;
    end
  endtask

  // hits: number of pressed intersections seen over the whole frame.
  task automatic model_frame(input int hits, input logic [3:0] code);
    if (!m_held) begin
      if (hits == 1 && m_run > 0 && code == m_cand) m_run++;
      else if (hits == 1 && m_run == 0) begin m_cand = code; m_run = 1; end
      else m_run = 0;
      if (m_run == DEB) begin
        model_accept(m_cand);
        m_held = 1'b1; m_run = 0; m_rel = 0;
      end
    end else if (hits == 0) begin
      m_rel++;
      if (m_rel == DEB) begin m_held = 1'b0; m_rel = 0; end
    end else begin
      m_rel = 0;
    end
  endtask

  // Edge k after reset release samples column (k/4-1)%4 every 4th edge, seeing the
  // keypad as it stood two edges earlier; column 3 closes the frame.
  task automatic model_edge();
    int col, h;
    logic [3:0] c_code;
    m_k++;
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (m_k % 4 == 0) begin
      col = ((m_k / 4) - 1) % 4;
      h = 0;
      c_code = 4'h0;
      for (int r = 0; r < 4; r++) begin
        if (m_hist1[col*4+r]) begin h++; c_code = key_at(col*4+r); end
      end
      m_acc_hits += h;
      if (h == 1) m_acc_code = c_code;
      if (col == 3) begin
        model_frame(m_acc_hits, m_acc_code);
        m_acc_hits = 0;
      end
    end
    m_hist1 = m_hist0;
    m_hist0 = mask;
    e_col = 4'hF ^ (4'h1 << ((m_k / 4) % 4));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("col_out",     int'(kp_if.col_out),     int'(e_col));
      check("key_code",    int'(kp_if.key_code),    int'(e_code));
      check("key_valid",   int'(kp_if.key_valid),   int'(e_valid));
      check("entry_done",  int'(kp_if.entry_done),  int'(e_done));
      check("Dig_1",       int'(kp_if.Dig_1),       int'(e_d1));
      check("Dig_2",       int'(kp_if.Dig_2),       int'(e_d2));
      check("Dig_3",       int'(kp_if.Dig_3),       int'(e_d3));
      check("Dig_4",       int'(kp_if.Dig_4),       int'(e_d4));
      check("entry_count", int'(kp_if.entry_count), int'(e_cnt));
      if (kp_if.key_valid === 1'b1) n_valid++;
      if (kp_if.entry_done === 1'b1) n_done++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic hold_key(input logic [3:0] code, input int cycles);
    @(negedge clk);
    mask = key_bit(code);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic release_all();
    mask = 16'h0;
    repeat (4 * FRAME) @(negedge clk);
  endtask

  task automatic tap(input logic [3:0] code);
    hold_key(code, 3 * FRAME + 4);
    release_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},   int'(kp_if.col_out),     'hE);
    check({tag, "_code"},  int'(kp_if.key_code),    0);
    check({tag, "_valid"}, int'(kp_if.key_valid),   0);
    check({tag, "_dig1"},  int'(kp_if.Dig_1),       0);
    check({tag, "_count"}, int'(kp_if.entry_count), 0);
  endtask

  initial begin
    int v0, d0;
    bit reached;
    reset = 1'b0;
    mask  = 16'h0;

    // Reset and scan
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check("scan_col", int'(kp_if.col_out), int'(4'hF ^ (4'h1 << ((i / 4) % 4))));
    end
    check("scan_count", int'(kp_if.entry_count), 0);
    check("scan_valid_total", n_valid, 0);

    // Single press of 5, then a long hold with no repeat
    v0 = n_valid;
    hold_key(4'h5, 3 * FRAME + 4);
    check("k5_pulses", n_valid - v0, 1);
    check("k5_code",   int'(kp_if.key_code),    5);
    check("k5_dig1",   int'(kp_if.Dig_1),       5);
    check("k5_count",  int'(kp_if.entry_count), 1);
    repeat (10 * FRAME) @(negedge clk);
    check("k5_no_repeat", n_valid - v0, 1);
    release_all();

    // Shift and saturation, then enter
    tap(4'h1); tap(4'h2); tap(4'h3); tap(4'h4); tap(4'h7);
    check("shift_dig4",  int'(kp_if.Dig_4),       2);
    check("shift_dig3",  int'(kp_if.Dig_3),       3);
    check("shift_dig2",  int'(kp_if.Dig_2),       4);
    check("shift_dig1",  int'(kp_if.Dig_1),       7);
    check("shift_count", int'(kp_if.entry_count), 4);
    d0 = n_done;
    tap(4'hE);
    check("enter_pulses", n_done - d0, 1);
    check("enter_code",   int'(kp_if.key_code), 'hE);
    check("enter_dig1",   int'(kp_if.Dig_1),    7);
    check("enter_dig4",   int'(kp_if.Dig_4),    2);
    check("enter_count",  int'(kp_if.entry_count), 4);

    // Bounce on key 8: pressed only while column 1 is not being sampled
    v0 = n_valid;
    reached = 1'b0;
    for (int i = 0; i < 32 && !reached; i++) begin
      @(negedge clk);
      if (m_k % 16 == 7) reached = 1'b1;
    end
    check("bounce_align", int'(reached), 1);
    for (int i = 0; i < 12; i++) begin
      mask = (i % 2 == 0) ? key_bit(4'h8) : 16'h0;
      repeat (8) @(negedge clk);
    end
    release_all();
    check("bounce_no_event", n_valid - v0, 0);

    // Two keys at once
    @(negedge clk);
    mask = key_bit(4'h1) | key_bit(4'h2);
    repeat (5 * FRAME) @(negedge clk);
    release_all();
    check("multi_no_event", n_valid - v0, 0);

    // Clear
    tap(4'hC);
    check("clear_pulses", n_valid - v0, 1);
    check("clear_code",   int'(kp_if.key_code),    'hC);
    check("clear_dig1",   int'(kp_if.Dig_1),       0);
    check("clear_dig4",   int'(kp_if.Dig_4),       0);
    check("clear_count",  int'(kp_if.entry_count), 0);

    // Reset mid-operation: during press debounce, then during hold
    tap(4'h6);
    check("pre_reset_dig1", int'(kp_if.Dig_1), 6);
    @(negedge clk);
    mask = key_bit(4'h9);
    reached = 1'b0;
    for (int i = 0; i < 5 * FRAME && !reached; i++) begin
      @(negedge clk);
      if (!m_held && m_run == 1) reached = 1'b1;
    end
    check("reach_press_pend", int'(reached), 1);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_pend");
    reset = 1'b1;
    v0 = n_valid;
    repeat (3 * FRAME + 4) @(negedge clk);
    check("after_pend_pulses", n_valid - v0, 1);
    check("after_pend_code",   int'(kp_if.key_code),    9);
    check("after_pend_dig1",   int'(kp_if.Dig_1),       9);
    check("after_pend_count",  int'(kp_if.entry_count), 1);

    check("reach_held", int'(m_held), 1);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_held");
    reset = 1'b1;
    v0 = n_valid;
    repeat (3 * FRAME + 4) @(negedge clk);
    check("after_held_pulses", n_valid - v0, 1);
    check("after_held_code",   int'(kp_if.key_code),    9);
    check("after_held_count",  int'(kp_if.entry_count), 1);
    release_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
